// File: rtl/logic_unit_pkg.sv
// Shared definitions for the registered bitwise logic unit: op encoding
// and the single-bit op function applied across every operand bit.
package logic_unit_pkg;

  localparam int LU_OP_W = 3;

  localparam logic [LU_OP_W-1:0] LU_OP_AND  = 3'd0;
  localparam logic [LU_OP_W-1:0] LU_OP_OR   = 3'd1;
  localparam logic [LU_OP_W-1:0] LU_OP_NAND = 3'd2;
  localparam logic [LU_OP_W-1:0] LU_OP_NOR  = 3'd3;
  localparam logic [LU_OP_W-1:0] LU_OP_XOR  = 3'd4;
  localparam logic [LU_OP_W-1:0] LU_OP_XNOR = 3'd5;
  localparam logic [LU_OP_W-1:0] LU_OP_NOT  = 3'd6;
  localparam logic [LU_OP_W-1:0] LU_OP_PASS = 3'd7;

  // One result bit from one bit of each operand; ops are purely bitwise,
  // so the full-width result is this function applied per bit position.
  function automatic logic lu_apply(input logic [LU_OP_W-1:0] op,
                                    input logic               a,
                                    input logic               b);
    logic r;
    case (op)
      LU_OP_AND:  r = a & b;
      LU_OP_OR:   r = a | b;
      LU_OP_NAND: r = ~(a & b);
      LU_OP_NOR:  r = ~(a | b);
      LU_OP_XOR:  r = a ^ b;
      LU_OP_XNOR: r = ~(a ^ b);
      LU_OP_NOT:  r = ~a;
      default:    r = a;  // LU_OP_PASS
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lu_skid_buf.sv
// One-entry skid buffer plus output register, valid/ready on both sides.
// in_ready depends only on registered state, so there is no combinational
// path from out_ready back to in_ready.
module lu_skid_buf #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic          skid_full;
  logic [PW-1:0] skid_data;
  logic          accept;
  logic          out_load;

  assign in_ready = ~skid_full;
  assign accept   = in_valid & in_ready;
  // Output register may take a new value when it is empty or being drained.
  assign out_load = ~out_valid | out_ready;

  // Output register and skid entry: skid drains first to keep FIFO order;
  // the skid only fills when an accept meets a stalled output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_full <= 1'b0;
      // NOTE: skid_data is reset too; it is a single register, and a known
      // value keeps the held payload deterministic at no real cost.
      skid_data <= '0;
    end else if (out_load) begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values; blocking would let skid_full ordering leak through.
      if (skid_full) begin
        out_data  <= skid_data;
        out_valid <= 1'b1;
        skid_full <= 1'b0;
      end else if (accept) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_data <= in_data;
      skid_full <= 1'b1;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit bitwise logic unit with valid/ready handshake and
// full throughput under backpressure. Optional zero/parity flags are
// enabled by defining LU_FLAGS_EN; they travel with the result.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [LU_OP_W-1:0] in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
`ifdef LU_FLAGS_EN
  ,
  output logic               out_zero,
  output logic               out_par
`endif
);

`ifdef LU_FLAGS_EN
  localparam int PW = WIDTH + 2;
`else
  localparam int PW = WIDTH;
`endif

  logic [WIDTH-1:0] res;
  logic [PW-1:0]    in_payload;
  logic [PW-1:0]    out_payload;

  // Combinational op on the input side; only registered after accept.
  always_comb begin
    // NOTE: default first so every bit is assigned on every pass and no
    // latch is inferred.
    res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res[i] = lu_apply(in_op, in_a[i], in_b[i]);
    end
  end

`ifdef LU_FLAGS_EN
  assign in_payload = {^res, ~|res, res};
  assign out_data   = out_payload[WIDTH-1:0];
  assign out_zero   = out_payload[WIDTH];
  assign out_par    = out_payload[WIDTH+1];
`else
  assign in_payload = res;
  assign out_data   = out_payload;
`endif

  lu_skid_buf #(
    .PW(PW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: the driver pushes expected results
// on accept, an independent monitor pops and compares on each output transfer.
module tb_logic_unit_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef LU_FLAGS_EN
  logic         out_zero;
  logic         out_par;
`endif

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef LU_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_par   (out_par)
`endif
  );

  typedef struct {
    logic [W-1:0] data;
    logic         zero;
    logic         par;
    int           cyc;
    logic         lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic lat_chk = 1'b0;
  logic stall_prev = 1'b0;
  logic [W-1:0] data_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: whole-word behaviour straight from the op table.
  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~(a & b);
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  task automatic push_exp(input logic [W-1:0] d);
    exp_t e;
    e.data = d;
    e.zero = (d == '0);
    e.par  = ^d;
    e.cyc  = cyc;
    e.lat  = lat_chk;
    sb.push_back(e);
  endtask

  task automatic wait_accept(input logic [W-1:0] d);
    int  n = 0;
    bit  done = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        push_exp(d);
        done = 1;
      end else begin
        n++;
        if (n > 50) begin
          check("accept_timeout", {31'd0, in_ready}, 32'd1);
          done = 1;
        end
      end
    end
  endtask

  task automatic send_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input logic [W-1:0] exp);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    wait_accept(exp);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    send_exp(a, b, op, ref_op(a, b, op));
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  // Monitor: compares every output transfer and the stability of stalled outputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_data", {24'd0, out_data}, {24'd0, data_prev});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", {31'd0, out_valid}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("data", {24'd0, out_data}, {24'd0, mon_e.data});
`ifdef LU_FLAGS_EN
          check("flag_zero", {31'd0, out_zero}, {31'd0, mon_e.zero});
          check("flag_par", {31'd0, out_par}, {31'd0, mon_e.par});
`endif
          if (mon_e.lat) check("latency", cyc - mon_e.cyc, 32'd1);
        end
      end
      stall_prev <= out_valid && !out_ready;
      data_prev  <= out_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] tab [8];
    logic [W-1:0] ra, rb;
    logic [2:0]   rop;
    tab[0] = 8'h24; tab[1] = 8'hBD; tab[2] = 8'hDB; tab[3] = 8'h42;
    tab[4] = 8'h99; tab[5] = 8'h66; tab[6] = 8'h5A; tab[7] = 8'hA5;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;

    // Reset state held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef LU_FLAGS_EN
      check("rst_zero", {31'd0, out_zero}, 32'd0);
      check("rst_par", {31'd0, out_par}, 32'd0);
`endif
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // All ops back-to-back with fixed operands.
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) send_exp(8'hA5, 8'h3C, 3'(i), tab[i]);
    idle();
    drain();
    lat_chk = 1'b0;

    // Backpressure: two held, third blocked until release.
    @(posedge clk); #1 out_ready = 1'b0;
    send(8'h11, 8'h22, 3'd1);
    send(8'h0F, 8'hF0, 3'd4);
    @(posedge clk); #1;
    in_a = 8'h77; in_b = 8'h70; in_op = 3'd0; in_valid = 1'b1;
    @(negedge clk);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_head", {24'd0, out_data}, 32'h33);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_accept(ref_op(8'h77, 8'h70, 3'd0));
    idle();
    drain();

    // Simultaneous accept+drain: continuous valid, one per cycle.
    lat_chk = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(W'($urandom), W'($urandom), 3'($urandom));
      if (i > 0) check("continuous_valid", {31'd0, out_valid}, 32'd1);
    end
    idle();
    drain();
    lat_chk = 1'b0;

    // Flag corner values (data checked in every build).
    send_exp(8'hFF, 8'hFF, 3'd4, 8'h00);
    send_exp(8'h01, 8'h02, 3'd1, 8'h03);
    idle();
    drain();

    // Mid-transaction reset with skid full: held results must vanish.
    @(posedge clk); #1 out_ready = 1'b0;
    send(8'hAA, 8'h55, 3'd1);
    send(8'hC3, 8'h3C, 3'd5);
    idle();
    @(negedge clk);
    check("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_idle", {31'd0, out_valid}, 32'd0);
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      ra = W'($urandom); rb = W'($urandom); rop = 3'($urandom);
      in_a = ra; in_b = rb; in_op = rop;
      @(negedge clk);
      if (in_valid && in_ready) push_exp(ref_op(ra, rb, rop));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
